// File: rtl/tmp8_control_sequencer.sv
// tmp8_control_sequencer
//
// Instruction-cycle controller for the TMP8 8-bit datapath. It steps through fetch, decode
// and execute, issuing one-cycle strobes to the PC, IR, MAR, ACC and flag registers. It also
// runs the single-port memory handshake and stops with a bus error if memory stalls too long.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   run        1 = execute, 0 = pause at the next instruction boundary
//   opcode     IR[7:4]
//   zero_flag  registered Z flag from the datapath
//   mem_ready  the current memory access completes this cycle
//   mar_load   load MAR; mar_sel picks the source (0 = PC, 1 = IR operand)
//   mem_rd     memory read request
//   mem_wr     memory write request (ACC to memory)
//   ir_load    load IR from memory data
//   pc_inc     PC <= PC + 1
//   pc_load    PC <= IR operand
//   acc_load   load ACC and flags from the ALU; alu_op: 00 PASS, 01 ADD, 10 SUB
//   halted     registered, high in HALT
//   bus_error  registered, sticky until reset
//   illegal_op registered one-cycle pulse after decoding an undefined opcode
//   state      current state, for debug
module tmp8_control_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mar_load,
  output logic       mar_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       bus_error,
  output logic       illegal_op,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StFetchAddr = 3'd0,
    StFetchMem  = 3'd1,
    StDecode    = 3'd2,
    StExecMem   = 3'd3,
    StHalt      = 3'd4
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpSta = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpJmp = 4'h5;
  localparam logic [3:0] OpJz  = 4'h6;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [1:0] AluPass = 2'b00;
  localparam logic [1:0] AluAdd  = 2'b01;
  localparam logic [1:0] AluSub  = 2'b10;

  // Last wait cycle in which a memory state may still complete.
  localparam logic [7:0] TmoLast = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] tmo_q, tmo_d;
  logic       halted_q, bus_error_q, illegal_q;
  logic       timeout, undef_op, is_wr;

  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    timeout  = 1'b0;
    undef_op = 1'b0;
    is_wr    = (opcode == OpSta);
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    acc_load = 1'b0;
    alu_op   = AluPass;

    case (state_q)
      StFetchAddr: begin
        if (run) begin
          mar_load = 1'b1;
          state_d  = StFetchMem;
          tmo_d    = '0;
        end
      end

      StFetchMem: begin
        if (mem_ready) begin
          mem_rd  = 1'b1;
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = StDecode;
        end else if (tmo_q == TmoLast) begin
          // Request is dropped in the timeout cycle itself.
          timeout = 1'b1;
          state_d = StHalt;
        end else begin
          mem_rd = 1'b1;
          tmo_d  = tmo_q + 8'd1;
        end
      end

      StDecode: begin
        state_d = StFetchAddr;
        case (opcode)
          OpNop: ;
          OpJmp: pc_load = 1'b1;
          OpJz:  pc_load = zero_flag;
          OpHlt: state_d = StHalt;
          OpLda, OpSta, OpAdd, OpSub: begin
            mar_load = 1'b1;
            mar_sel  = 1'b1;
            state_d  = StExecMem;
            tmo_d    = '0;
          end
          default: undef_op = 1'b1;
        endcase
      end

      StExecMem: begin
        if (mem_ready) begin
          mem_rd  = !is_wr;
          mem_wr  = is_wr;
          state_d = StFetchAddr;
          case (opcode)
            OpLda: begin
              acc_load = 1'b1;
              alu_op   = AluPass;
            end
            OpAdd: begin
              acc_load = 1'b1;
              alu_op   = AluAdd;
            end
            OpSub: begin
              acc_load = 1'b1;
              alu_op   = AluSub;
            end
            default: ;
          endcase
        end else if (tmo_q == TmoLast) begin
          timeout = 1'b1;
          state_d = StHalt;
        end else begin
          mem_rd = !is_wr;
          mem_wr = is_wr;
          tmo_d  = tmo_q + 8'd1;
        end
      end

      StHalt: ;

      default: state_d = StFetchAddr;
    endcase

    if (reset) begin
      mar_load = 1'b0;
      mar_sel  = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      acc_load = 1'b0;
      alu_op   = AluPass;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StFetchAddr;
      tmo_q       <= '0;
      halted_q    <= 1'b0;
      bus_error_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      halted_q  <= (state_d == StHalt);
      illegal_q <= undef_op;
      if (timeout) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  assign halted     = halted_q;
  assign bus_error  = bus_error_q;
  assign illegal_op = illegal_q;
  assign state      = state_q;

endmodule

// File: tb/tb_tmp8_control_sequencer.sv
module tb_tmp8_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode;
  logic       zero_flag, mem_ready;
  logic       mar_load, mar_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load;
  logic [1:0] alu_op;
  logic       halted, bus_error, illegal_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  tmp8_control_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .zero_flag  (zero_flag),
    .mem_ready  (mem_ready),
    .mar_load   (mar_load),
    .mar_sel    (mar_sel),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_load    (ir_load),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .acc_load   (acc_load),
    .alu_op     (alu_op),
    .halted     (halted),
    .bus_error  (bus_error),
    .illegal_op (illegal_op),
    .state      (state)
  );

  // Strobe bit positions: {mar_load, mar_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load,
  // acc_load, alu_op[1:0]}
  localparam logic [9:0] ML = 10'h200, MS = 10'h100, RD = 10'h080, WR = 10'h040;
  localparam logic [9:0] IL = 10'h020, PI = 10'h010, PL = 10'h008, AL = 10'h004;
  localparam logic [9:0] AADD = 10'h001, ASUB = 10'h002;
  localparam logic [9:0] FT = RD | IL | PI;

  typedef struct {
    string      name;
    logic       rst, run;
    logic [3:0] op;
    logic       z, rdy;
    logic [2:0] st;
    logic [9:0] strb;
    logic       hlt, berr, ill;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [1:0] alu;
  } acc_ev_t;

  vec_t       tbl[$];
  vec_t       exp_q[$];
  acc_ev_t    acc_q[$];
  logic [7:0] fetch_q[$];

  int total = 0;
  int bad = 0;

  // Part A drives the controller inputs directly; part B closes the loop through a small
  // datapath and memory model.
  logic       mode_b = 1'b0;
  logic [3:0] tb_op = 4'h0;
  logic       tb_z = 1'b0, tb_rdy = 1'b1;
  logic       done = 1'b0;
  int         cyc = 0;

  logic [7:0] pc, ir, mar, acc;
  logic       zf;
  logic [7:0] mem [0:15];
  logic [7:0] rdata;

  assign rdata     = mem[mar[3:0]];
  assign opcode    = mode_b ? ir[7:4] : tb_op;
  assign zero_flag = mode_b ? zf : tb_z;
  assign mem_ready = mode_b ? 1'b1 : tb_rdy;

  always @(posedge clk) begin
    if (reset) begin
      pc  <= 8'h00;
      ir  <= 8'h00;
      mar <= 8'h00;
      acc <= 8'h00;
      zf  <= 1'b0;
    end else begin
      if (mar_load) mar <= mar_sel ? {4'h0, ir[3:0]} : pc;
      if (ir_load) ir <= rdata;
      if (pc_inc) pc <= pc + 8'd1;
      if (pc_load) pc <= {4'h0, ir[3:0]};
      if (acc_load) begin
        case (alu_op)
          2'b01:   begin acc <= acc + rdata; zf <= ((acc + rdata) == 8'h00); end
          2'b10:   begin acc <= acc - rdata; zf <= ((acc - rdata) == 8'h00); end
          default: begin acc <= rdata;       zf <= (rdata == 8'h00); end
        endcase
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic rs, input logic ru,
                              input logic [3:0] o, input logic zz, input logic rd,
                              input logic [2:0] s, input logic [9:0] sb, input logic h,
                              input logic b, input logic i);
    vec_t v;
    v.name = n; v.rst = rs; v.run = ru; v.op = o; v.z = zz; v.rdy = rd;
    v.st = s; v.strb = sb; v.hlt = h; v.berr = b; v.ill = i;
    return v;
  endfunction

  // Single checking process: every comparison happens here.
  always @(negedge clk) begin
    if (!mode_b) begin
      if (exp_q.size() > 0) begin
        vec_t       v;
        logic [9:0] m, act;
        v   = exp_q.pop_front();
        act = {mar_load, mar_sel, mem_rd, mem_wr, ir_load, pc_inc, pc_load, acc_load, alu_op};
        m   = 10'h3FF;
        if (!v.strb[9]) m[8] = 1'b0;
        if (!v.strb[2]) m[1:0] = 2'b00;
        check({v.name, ".state"}, int'(state), int'(v.st));
        check({v.name, ".strobes"}, int'(act & m), int'(v.strb & m));
        check({v.name, ".halted"}, int'(halted), int'(v.hlt));
        check({v.name, ".bus_error"}, int'(bus_error), int'(v.berr));
        check({v.name, ".illegal_op"}, int'(illegal_op), int'(v.ill));
      end
    end else if (!done) begin
      if (reset) begin
        cyc = 0;
      end else begin
        if (acc_load) begin
          if (acc_q.size() == 0) begin
            check("prog.extra_acc_load", cyc, -1);
          end else begin
            acc_ev_t e;
            e = acc_q.pop_front();
            check("prog.acc_load_cycle", cyc, e.cyc);
            check("prog.alu_op", int'(alu_op), int'(e.alu));
          end
        end
        if (mar_load && !mar_sel) begin
          if (fetch_q.size() == 0) check("prog.extra_fetch", int'(pc), -1);
          else check("prog.fetch_addr", int'(pc), int'(fetch_q.pop_front()));
        end
        if (mem_rd && mem_wr) check("prog.rd_wr_overlap", 1, 0);
        if (pc_inc && pc_load) check("prog.pc_overlap", 1, 0);
        if (cyc == 8) check("prog.acc_after_add", int'(acc), 32'h32);
        if (halted) begin
          check("prog.halt_cycle", cyc, 21);
          check("prog.final_acc", int'(acc), 0);
          check("prog.final_z", int'(zf), 1);
          check("prog.final_pc", int'(pc), 32'h0D);
          check("prog.bus_error", int'(bus_error), 0);
          check("prog.acc_events_left", acc_q.size(), 0);
          check("prog.fetches_left", fetch_q.size(), 0);
          done = 1'b1;
        end else if (cyc >= 60) begin
          check("prog.halt_timeout", int'(halted), 1);
          done = 1'b1;
        end
        cyc++;
      end
    end
  end

  initial begin
    // Program: LDA 5; ADD 6; JZ A (not taken); SUB 7; JZ C (taken); ... C: HLT
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0]  = 8'h15;
    mem[1]  = 8'h36;
    mem[2]  = 8'h6A;
    mem[3]  = 8'h47;
    mem[4]  = 8'h6C;
    mem[5]  = 8'h10;
    mem[6]  = 8'h22;
    mem[7]  = 8'h32;
    mem[12] = 8'hF0;

    // name, rst, run, op, z, rdy, state, strobes, halted, bus_error, illegal_op
    tbl.push_back(mk("nop", 0, 1, 4'h0, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("nop", 0, 1, 4'h0, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("nop", 0, 1, 4'h0, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("nop", 0, 1, 4'h0, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("nop", 0, 1, 4'h0, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("nop", 0, 1, 4'h0, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("jz0", 0, 1, 4'h6, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("jz0", 0, 1, 4'h6, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("jz0", 0, 1, 4'h6, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("jz1", 0, 1, 4'h6, 1, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("jz1", 0, 1, 4'h6, 1, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("jz1", 0, 1, 4'h6, 1, 1, 2, PL, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 1, 2, ML | MS, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 0, 3, WR, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 0, 3, WR, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 0, 3, WR, 0, 0, 0));
    tbl.push_back(mk("sta", 0, 1, 4'h2, 0, 1, 3, WR, 0, 0, 0));
    tbl.push_back(mk("lda", 0, 1, 4'h1, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("lda", 0, 1, 4'h1, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("lda", 0, 1, 4'h1, 0, 1, 2, ML | MS, 0, 0, 0));
    tbl.push_back(mk("lda", 0, 1, 4'h1, 0, 1, 3, RD | AL, 0, 0, 0));
    tbl.push_back(mk("sub", 0, 1, 4'h4, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("sub", 0, 1, 4'h4, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("sub", 0, 1, 4'h4, 0, 1, 2, ML | MS, 0, 0, 0));
    tbl.push_back(mk("sub", 0, 1, 4'h4, 0, 1, 3, RD | AL | ASUB, 0, 0, 0));
    tbl.push_back(mk("ill", 0, 1, 4'h9, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("ill", 0, 1, 4'h9, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("ill", 0, 1, 4'h9, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("jmp", 0, 1, 4'h5, 0, 1, 0, ML, 0, 0, 1));
    tbl.push_back(mk("jmp", 0, 1, 4'h5, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("jmp", 0, 1, 4'h5, 0, 1, 2, PL, 0, 0, 0));
    tbl.push_back(mk("pause", 0, 0, 4'h5, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("pause", 0, 0, 4'h5, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 0, 1, RD, 0, 0, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 0, 1, RD, 0, 0, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 0, 1, RD, 0, 0, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 0, 4, 0, 1, 1, 0));
    tbl.push_back(mk("tmo", 0, 1, 4'h0, 0, 1, 4, 0, 1, 1, 0));
    tbl.push_back(mk("rst", 1, 1, 4'h0, 0, 1, 4, 0, 1, 1, 0));
    tbl.push_back(mk("late", 0, 1, 4'h0, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("late", 0, 1, 4'h0, 0, 0, 1, RD, 0, 0, 0));
    tbl.push_back(mk("late", 0, 1, 4'h0, 0, 0, 1, RD, 0, 0, 0));
    tbl.push_back(mk("late", 0, 1, 4'h0, 0, 0, 1, RD, 0, 0, 0));
    tbl.push_back(mk("late", 0, 1, 4'hF, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("hlt", 0, 1, 4'hF, 0, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk("hlt", 0, 1, 4'hF, 0, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk("hlt", 0, 1, 4'hF, 0, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk("rst2", 1, 0, 4'hF, 0, 1, 4, 0, 1, 0, 0));
    tbl.push_back(mk("idle", 0, 0, 4'h3, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("idle", 0, 0, 4'h3, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rstx", 0, 1, 4'h3, 0, 1, 0, ML, 0, 0, 0));
    tbl.push_back(mk("rstx", 0, 1, 4'h3, 0, 1, 1, FT, 0, 0, 0));
    tbl.push_back(mk("rstx", 0, 1, 4'h3, 0, 1, 2, ML | MS, 0, 0, 0));
    tbl.push_back(mk("rstx", 0, 1, 4'h3, 0, 0, 3, RD, 0, 0, 0));
    tbl.push_back(mk("rstx", 1, 0, 4'h3, 0, 0, 3, 0, 0, 0, 0));
    tbl.push_back(mk("rstx", 0, 0, 4'h3, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rstx", 0, 0, 4'h3, 0, 1, 0, 0, 0, 0, 0));

    // Initial reset, not checked.
    reset = 1'b1;
    run   = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      reset  = tbl[i].rst;
      run    = tbl[i].run;
      tb_op  = tbl[i].op;
      tb_z   = tbl[i].z;
      tb_rdy = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
    end
    @(negedge clk);
    #1;

    // Part B: expected ACC loads and fetch addresses for the program above.
    acc_q.push_back('{cyc: 3, alu: 2'b00});
    acc_q.push_back('{cyc: 7, alu: 2'b01});
    acc_q.push_back('{cyc: 14, alu: 2'b10});
    fetch_q.push_back(8'h00);
    fetch_q.push_back(8'h01);
    fetch_q.push_back(8'h02);
    fetch_q.push_back(8'h03);
    fetch_q.push_back(8'h04);
    fetch_q.push_back(8'h0C);
    mode_b = 1'b1;
    reset  = 1'b1;
    run    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 100 && !done; i++) @(posedge clk);
    if (!done) begin
      $display("FAIL prog.stalled: got done=0 want done=1");
      $fatal(1, "program phase did not complete");
    end
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
